// File: rtl/pack256_pkg.sv
// pack256_pkg -- shared constants and sizing helpers for the pack256 width packer.
//
// Contents:
//   OUT_W           packed word width (256 for this stage)
//   calc_nbeats()   beats per packed word for a given beat width
//   calc_beats_w()  width of the beats_o fill count for a given beat width
//   in_w_valid()    true when a beat width tiles OUT_W exactly with >= 2 beats
//
// Optional feature macro used by the files importing this package:
//   PACK256_MSB_FIRST_EN
package pack256_pkg;

   localparam int OUT_W = 256;

   function automatic int calc_nbeats(input int in_w);
      return OUT_W / in_w;
   endfunction

   // beats_o must be able to hold the full count NBEATS, not just NBEATS-1.
   function automatic int calc_beats_w(input int in_w);
      return $clog2(calc_nbeats(in_w) + 1);
   endfunction

   function automatic bit in_w_valid(input int in_w);
      return (in_w > 0) && ((OUT_W % in_w) == 0) && ((OUT_W / in_w) >= 2);
   endfunction

endpackage

// File: rtl/pack256_if.sv
// pack256_if -- beat-in / word-out bus of the pack256 width packer.
//
// Handshakes (both sides use the same rule):
//   a transfer happens on a rising clk edge where the valid signal and the
//   matching ready signal are both 1; the sender keeps its data and valid
//   stable until that edge, the receiver may change ready at any time.
//   Beat side: valid_i/ready_o with d_i, last_i.
//   Word side: valid_o/ready_i with d_o, beats_o.
//
// Modports:
//   master  the environment: beat source and word sink
//   slave   the packer itself
interface pack256_if #(
   parameter int IN_W = 32
);
   import pack256_pkg::*;

   localparam int BEATS_W = calc_beats_w(IN_W);

   logic [IN_W-1:0]    d_i;
   logic               valid_i;
   logic               last_i;
   logic               ready_o;
   logic [OUT_W-1:0]   d_o;
   logic               valid_o;
   logic               ready_i;
   logic [BEATS_W-1:0] beats_o;

   modport master (
      output d_i, valid_i, last_i, ready_i,
      input  ready_o, d_o, valid_o, beats_o
   );

   modport slave (
      input  d_i, valid_i, last_i, ready_i,
      output ready_o, d_o, valid_o, beats_o
   );

endinterface

// File: rtl/pack256_acc.sv
// pack256_acc -- lane accumulator, beat counter and completion detect.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear_i      synchronous discard of the partial word
//   accept       a beat is taken this cycle
//   last         the accepted beat closes the word early
//   beat         beat data
//   complete     this accept finishes a word (combinational)
//   word         accumulator merged with the current beat (combinational)
//   beats        fill count of word, beat_cnt+1 (combinational)
//
// Lane order: LSB lane first by default; with PACK256_MSB_FIRST_EN defined,
// beat k lands in lane NBEATS-1-k.
module pack256_acc
   import pack256_pkg::*;
#(
   parameter int IN_W = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              clear_i,
   input  logic                              accept,
   input  logic                              last,
   input  logic [IN_W-1:0]                   beat,
   output logic                              complete,
   output logic [OUT_W-1:0]                  word,
   output logic [calc_beats_w(IN_W)-1:0]     beats
);

   localparam int NBEATS  = calc_nbeats(IN_W);
   localparam int CNT_W   = $clog2(NBEATS);
   localparam int BEATS_W = calc_beats_w(IN_W);
   localparam int SH_W    = $clog2(OUT_W);

   logic [OUT_W-1:0] acc;
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] lane;
   logic [SH_W-1:0]  shamt;

`ifdef PACK256_MSB_FIRST_EN
   assign lane = CNT_W'(NBEATS - 1) - beat_cnt;
`else
   assign lane = beat_cnt;
`endif

   // Unfilled lanes of acc are always 0, so OR-ing the shifted beat is a
   // lane write.
   assign shamt    = SH_W'(lane) * SH_W'(IN_W);
   assign word     = acc | (OUT_W'(beat) << shamt);
   assign complete = accept && (last || (beat_cnt == CNT_W'(NBEATS - 1)));
   assign beats    = BEATS_W'(beat_cnt) + BEATS_W'(1);

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else if (complete) begin
         acc      <= '0;
         beat_cnt <= '0;
      end else if (accept) begin
         acc      <= word;
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pack256.sv
// pack256 -- packs IN_W-bit beats into 256-bit words for the capture latch.
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset
//   clear_i  synchronous flush-and-discard, same effect as reset
//   bus      pack256_if.slave: d_i/valid_i/last_i/ready_o beat side,
//            d_o/valid_o/ready_i/beats_o word side
//
// A word completes after NBEATS beats or on a beat with last_i; it appears on
// d_o one cycle after the completing accept and is held until ready_i.
// ready_o = !valid_o || ready_i, so a word can be replaced in the cycle it is
// consumed and beats stream with no bubble.
//
// Optional feature: PACK256_MSB_FIRST_EN reverses lane order (see pack256_acc).
module pack256
   import pack256_pkg::*;
#(
   parameter int IN_W = 32
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     clear_i,
   pack256_if.slave bus
);

   localparam int BEATS_W = calc_beats_w(IN_W);

   if (!in_w_valid(IN_W)) begin : g_bad_in_w
      $error("pack256: IN_W must divide 256 with at least two beats per word");
   end

   logic               accept;
   logic               complete;
   logic [OUT_W-1:0]   word;
   logic [BEATS_W-1:0] beats;

   logic [OUT_W-1:0]   d_q;
   logic               valid_q;
   logic [BEATS_W-1:0] beats_q;

   assign bus.ready_o = !valid_q || bus.ready_i;
   assign accept      = bus.valid_i && bus.ready_o;

   pack256_acc #(
      .IN_W(IN_W)
   ) u_acc (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_i),
      .accept  (accept),
      .last    (bus.last_i),
      .beat    (bus.d_i),
      .complete(complete),
      .word    (word),
      .beats   (beats)
   );

   // Output hold register. d_q/beats_q keep their last value after a
   // transfer; only valid_q falls.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         d_q     <= '0;
         beats_q <= '0;
         valid_q <= 1'b0;
      end else if (complete) begin
         d_q     <= word;
         beats_q <= beats;
         valid_q <= 1'b1;
      end else if (valid_q && bus.ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.d_o     = d_q;
   assign bus.valid_o = valid_q;
   assign bus.beats_o = beats_q;

endmodule

// File: doc/pack256.md
Name: pack256

Overview:
- Upstream width-packing stage that feeds the 256-bit capture latch.
- Accepts narrow IN_W-bit beats over a valid/ready handshake and assembles them LSB-lane-first into one 256-bit word.
- Presents each completed word on d_o/valid_o, held until consumed.
- A last_i marker flushes a partial word, zero-padded, with a beat count.

Parameters:
- IN_W, 32, beat width; must divide OUT_W exactly; NBEATS = OUT_W/IN_W must be >= 2.
- OUT_W, 256, packed word width; fixed at 256 for this stage.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- clear_i  input  1  synchronous flush-and-discard; same effect as reset
- d_i  input  IN_W  input beat
- valid_i  input  1  beat valid
- last_i  input  1  qualifies the current beat as final beat of a word; ignored without valid_i
- ready_o  output  1  beat accepted when valid_i && ready_o
- d_o  output  256  packed word
- valid_o  output  1  word valid; held until ready_i
- ready_i  input  1  downstream accept; tie 1 when driving the capture latch
- beats_o  output  $clog2(NBEATS+1)  number of filled lanes in d_o (4 bits for NBEATS=8)

Behaviour:
- Reset state (reset or clear_i high at a clock edge):
  - Accumulator = 0, beat_cnt = 0, d_o = 0, valid_o = 0, beats_o = 0.
  - reset/clear_i take priority over all other inputs; a beat presented in the same cycle is dropped.
  - clear_i during a held valid_o drops valid_o.
- ready_o = !valid_o || ready_i, purely combinational, so there is a ready_i -> ready_o path. ready_o reads 1 out of reset.
- Lane placement: accepted beat k (0-based within the word) is written to bits [k*IN_W +: IN_W].
- Word completion: the accepted beat completes a word when beat_cnt == NBEATS-1, or when last_i = 1.
- On the completing accept:
  - d_o is loaded next edge with the accumulator plus the new beat; unfilled lanes are 0.
  - beats_o = beat_cnt+1; valid_o = 1.
  - Accumulator and beat_cnt return to 0 on the same edge.
- Latency: valid_o rises 1 cycle after the completing beat is accepted.
- Throughput: one beat per cycle, no bubble between words while ready_i = 1.
- Hold: while valid_o && !ready_i, d_o and beats_o are stable and ready_o = 0. No beats are accepted, including non-completing ones.
- Transfer occurs when valid_o && ready_i:
  - With a completing accept in the same cycle, d_o reloads and valid_o stays 1.
  - Otherwise valid_o falls next cycle and d_o keeps its last value.
- last_i on beat 0 produces a word with lane 0 only and beats_o = 1.
- last_i on beat NBEATS-1 is equivalent to a normal completion.
- There is no empty-word flush: last_i without valid_i has no effect.
- Non-accepted beats (valid_i && !ready_o) must be held by the source; no state changes.

Optional Feature:
- Macro: PACK256_MSB_FIRST_EN.
- Defined: beat k lands at lane NBEATS-1-k. Partial words fill from the top lane down, low unfilled lanes are 0, and beats_o is unchanged.
- Undefined: LSB-lane-first placement as specified above.

Decomposition:
- Shared package pack256_pkg holds:
  - localparam OUT_W = 256;
  - a function computing NBEATS and the beats_o width from IN_W;
  - an elaboration-time check that IN_W divides OUT_W.
- One sub-module is natural: pack256_acc, containing the lane accumulator, beat counter and completion detect.
- The top level holds the output hold register and the handshake logic.

Test Plan:
- Full word: IN_W=32, ready_i=1, beats 32'hA0..32'hA7 back-to-back, last_i=0 -> one cycle after the 8th accept:
  - valid_o=1, d_o[31:0]=A0, d_o[255:224]=A7, beats_o=8;
  - valid_o=0 on the following cycle.
- Partial flush: beats 1, 2, 3 with last_i on the 3rd -> d_o={160'h0,32'h3,32'h2,32'h1}, beats_o=3.
- Backpressure: complete a word with ready_i=0 for 4 cycles ->
  - valid_o held, d_o stable, ready_o=0, offered beats not accepted;
  - ready_i=1 -> transfer, ready_o=1 the same cycle.
- Back-to-back: 16 consecutive beats with ready_i=1 ->
  - valid_o high 1 cycle after accepts 8 and 16;
  - second word lanes hold beats 8..15 only, with no stale data.
- Clear mid-word: 5 beats then clear_i=1 -> beat_cnt=0. The next 8 beats 32'hB0..B7 produce d_o with B0 in lane 0 and no lanes from before the clear.
- Reset while valid_o is held (ready_i=0) -> next cycle valid_o=0, d_o=0, beats_o=0, ready_o=1.
- MSB-first build: beat 32'hC0 with last_i -> d_o[255:224]=C0, all other bits 0, beats_o=1.
